// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 round-robin channel multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 8;

  // Ceiling log2, never below 1 so a 1-bit index survives degenerate sizes.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr, else lowest overall.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int SW = clog2(DEFAULT_N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign upper_mask[gi] = (SW'(gi) >= ptr);
  end

  assign upper_req = req & upper_mask;
  assign any       = |req;

  // Isolating the lowest set bit (x & -x) gives the wrap-around search without a loop.
  assign grant = (|upper_req) ? (upper_req & (~upper_req + N'(1)))
                              : (req & (~req + N'(1)));

  for (genvar gb = 0; gb < SW; gb++) begin : g_idx
    logic [N-1:0] col;
    for (genvar gi = 0; gi < N; gi++) begin : g_col
      assign col[gi] = 1'(gi >> gb);
    end
    assign grant_idx[gb] = |(grant & col);
  end

endmodule

// File: rtl/mux_rr_n1.sv
// N:1 channel multiplexer with registered output, valid/ready on every port,
// and manual or round-robin channel selection.
module mux_rr_n1
  import mux_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  parameter  int W  = DEFAULT_W,
  localparam int SW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_ch
);

  logic [W-1:0]  chan [N];
  logic [N-1:0]  arb_grant;
  logic [N-1:0]  man_onehot;
  logic [SW-1:0] arb_idx;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr_reg;
  logic [SW-1:0] ptr_next;
  logic          arb_any;
  logic          rr_mode;
  logic          g_ok;
  logic          load_en;
  logic          accept;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign chan[gi]       = in_data[gi*W +: W];
    assign man_onehot[gi] = (sel == SW'(gi));
  end

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign rr_mode = (mode == MODE_RR);
  assign load_en = !out_valid || out_ready;
  assign g       = rr_mode ? arb_idx : sel;
  // An out-of-range manual sel (non-power-of-2 N) grants nothing.
  assign g_ok    = rr_mode ? arb_any : (int'(sel) < N);

  assign in_ready = (rst_n && load_en && g_ok) ? (rr_mode ? arb_grant : man_onehot) : '0;
  assign accept   = |(in_ready & in_valid);
  assign ptr_next = (int'(g) == N - 1) ? '0 : g + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr_reg   <= '0;
    end else if (accept) begin
      out_data  <= chan[g];
      out_ch    <= g;
      out_valid <= 1'b1;
      if (rr_mode) ptr_reg <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_n1.sv
// Directed and soak bench for mux_rr_n1 with a 4-channel and a 5-channel instance.
module tb_mux_rr_n1;
  import mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic        mode4, out_valid4, out_ready4;
  logic [1:0]  sel4, out_ch4;
  logic [7:0]  out_data4;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic        mode5, out_valid5, out_ready5;
  logic [2:0]  sel5, out_ch5;
  logic [7:0]  out_data5;

  int total = 0;
  int bad   = 0;
  logic [7:0] ch_data4 [4] = '{8'hC0, 8'hC1, 8'hA5, 8'hC3};

  mux_rr_n1 #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .mode(mode4), .sel(sel4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_ch(out_ch4)
  );

  mux_rr_n1 #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .mode(mode5), .sel(sel5), .out_data(out_data5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_ch(out_ch5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid4 = '0;
    in_valid5 = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data4 = {8'hC3, 8'hA5, 8'hC1, 8'hC0};
    in_valid4 = 4'b1111; mode4 = MODE_RR; sel4 = 2'd0; out_ready4 = 1'b0;
    in_data5 = {8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
    in_valid5 = '0; mode5 = MODE_MANUAL; sel5 = 3'd0; out_ready5 = 1'b0;
    repeat (2) tick();
    total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready4); end
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid4); end
    rst_n = 1'b1;
    tick();
    total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL load_valid got=%b exp=1", out_valid4); end
    total++; if (out_data4 !== 8'hC0) begin bad++; $display("FAIL load_data got=%h exp=c0", out_data4); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid4); end
    total++; if (out_data4 !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", out_data4); end
    total++; if (out_ch4 !== 2'd0) begin bad++; $display("FAIL midrst_ch got=%0d exp=0", out_ch4); end
    total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL midrst_in_ready got=%b exp=0000", in_ready4); end
    #1 rst_n = 1'b1;
    out_ready4 = 1'b1;
    #1;
    total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL postrst_grant got=%b exp=0001", in_ready4); end
    tick();
    total++; if (out_ch4 !== 2'd0) begin bad++; $display("FAIL postrst_ch got=%0d exp=0", out_ch4); end
  endtask

  task automatic test_manual();
    mode4 = MODE_MANUAL; sel4 = 2'd2; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    #1;
    total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL man_ready got=%b exp=0100", in_ready4); end
    tick();
    total++; if (out_data4 !== 8'hA5) begin bad++; $display("FAIL man_data got=%h exp=a5", out_data4); end
    total++; if (out_ch4 !== 2'd2) begin bad++; $display("FAIL man_ch got=%0d exp=2", out_ch4); end
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL man_stream_ready got=%b exp=0100", in_ready4); end
      tick();
      total++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd2) begin bad++; $display("FAIL man_stream got=%b/%0d exp=1/2", out_valid4, out_ch4); end
    end
    sel4 = 2'd3;
    #1;
    total++; if (in_ready4 !== 4'b1000) begin bad++; $display("FAIL man_sel3_ready got=%b exp=1000", in_ready4); end
    tick();
    total++; if (out_data4 !== 8'hC3) begin bad++; $display("FAIL man_sel3_data got=%h exp=c3", out_data4); end
    sel4 = 2'd1; in_valid4 = 4'b0000;
    #1;
    total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL man_novalid_ready got=%b exp=0010", in_ready4); end
    tick();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL man_drain got=%b exp=0", out_valid4); end
  endtask

  task automatic test_rr_fair();
    do_reset();
    mode4 = MODE_RR; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      int e;
      e = i % 4;
      total++; if (in_ready4 !== 4'(1 << e)) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, in_ready4, 4'(1 << e)); end
      tick();
      total++; if (out_ch4 !== 2'(e) || out_data4 !== ch_data4[e]) begin bad++; $display("FAIL rr_seq[%0d] got=%0d/%h exp=%0d/%h", i, out_ch4, out_data4, e, ch_data4[e]); end
    end
    in_valid4 = 4'b0010;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL rr_ch1_ready got=%b exp=0010", in_ready4); end
      tick();
      total++; if (out_ch4 !== 2'd1) begin bad++; $display("FAIL rr_ch1 got=%0d exp=1", out_ch4); end
    end
  endtask

  task automatic test_backpressure();
    in_valid4 = 4'b1111; out_ready4 = 1'b1;
    #1;
    tick();
    total++; if (out_ch4 !== 2'd2) begin bad++; $display("FAIL bp_first got=%0d exp=2", out_ch4); end
    out_ready4 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL bp_ready got=%b exp=0000", in_ready4); end
      tick();
      total++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd2 || out_data4 !== 8'hA5) begin bad++; $display("FAIL bp_hold got=%b/%0d/%h exp=1/2/a5", out_valid4, out_ch4, out_data4); end
    end
    out_ready4 = 1'b1;
    #1;
    total++; if (in_ready4 !== 4'b1000) begin bad++; $display("FAIL bp_resume_ready got=%b exp=1000", in_ready4); end
    tick();
    total++; if (out_ch4 !== 2'd3) begin bad++; $display("FAIL bp_resume_ch got=%0d exp=3", out_ch4); end
    in_valid4 = 4'b0000;
    tick();
    total++; if (out_valid4 !== 1'b0 || out_data4 !== 8'hC3) begin bad++; $display("FAIL bp_drain got=%b/%h exp=0/c3", out_valid4, out_data4); end
  endtask

  task automatic test_nonpow2();
    mode5 = MODE_MANUAL; sel5 = 3'd6; in_valid5 = 5'b11111; out_ready5 = 1'b0;
    #1;
    total++; if (in_ready5 !== 5'b00000) begin bad++; $display("FAIL n5_sel6_ready got=%b exp=00000", in_ready5); end
    tick();
    total++; if (out_valid5 !== 1'b0) begin bad++; $display("FAIL n5_sel6_valid got=%b exp=0", out_valid5); end
    sel5 = 3'd4;
    #1;
    total++; if (in_ready5 !== 5'b10000) begin bad++; $display("FAIL n5_sel4_ready got=%b exp=10000", in_ready5); end
    mode5 = MODE_RR; in_valid5 = 5'b01000;
    #1;
    total++; if (in_ready5 !== 5'b01000) begin bad++; $display("FAIL n5_rr3_ready got=%b exp=01000", in_ready5); end
    tick();
    total++; if (out_ch5 !== 3'd3 || out_data5 !== 8'h53) begin bad++; $display("FAIL n5_rr3 got=%0d/%h exp=3/53", out_ch5, out_data5); end
    out_ready5 = 1'b1; in_valid5 = 5'b00001;
    #1;
    total++; if (in_ready5 !== 5'b00001) begin bad++; $display("FAIL n5_wrap_ready got=%b exp=00001", in_ready5); end
    tick();
    total++; if (out_ch5 !== 3'd0 || out_data5 !== 8'h50) begin bad++; $display("FAIL n5_wrap got=%0d/%h exp=0/50", out_ch5, out_data5); end
  endtask

  task automatic test_mode_switch();
    mode4 = MODE_RR; in_valid4 = 4'b0010; out_ready4 = 1'b1;
    #1;
    tick();
    total++; if (out_ch4 !== 2'd1) begin bad++; $display("FAIL ms_setup got=%0d exp=1", out_ch4); end
    mode4 = MODE_MANUAL; sel4 = 2'd0; in_valid4 = 4'b1111;
    #1;
    total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL ms_manual_ready got=%b exp=0001", in_ready4); end
    repeat (2) tick();
    total++; if (out_ch4 !== 2'd0 || out_data4 !== 8'hC0) begin bad++; $display("FAIL ms_manual got=%0d/%h exp=0/c0", out_ch4, out_data4); end
    mode4 = MODE_RR;
    #1;
    total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL ms_rr_ready got=%b exp=0100", in_ready4); end
    tick();
    total++; if (out_ch4 !== 2'd2) begin bad++; $display("FAIL ms_rr_ch got=%0d exp=2", out_ch4); end
    in_valid4 = 4'b0000;
    tick();
  endtask

  task automatic test_soak();
    int sent [4];
    int recv [4];
    logic [7:0] exp_b;
    logic [3:0] in_x;
    for (int k = 0; k < 4; k++) begin sent[k] = 0; recv[k] = 0; end
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (cyc < 300) begin
        in_valid4  = 4'($urandom);
        out_ready4 = ($urandom_range(0, 3) != 0);
        mode4      = 1'($urandom);
        sel4       = 2'($urandom);
      end else begin
        in_valid4  = 4'b0000;
        out_ready4 = 1'b1;
      end
      for (int k = 0; k < 4; k++) in_data4[k*8 +: 8] = {2'(k), 6'(sent[k])};
      #2;
      total++; if (!$onehot0(in_ready4)) begin bad++; $display("FAIL soak_onehot got=%b exp=onehot0", in_ready4); end
      in_x = in_valid4 & in_ready4;
      if (out_valid4 && out_ready4) begin
        exp_b = {out_ch4, 6'(recv[out_ch4])};
        total++; if (out_data4 !== exp_b) begin bad++; $display("FAIL soak_order ch=%0d got=%h exp=%h", out_ch4, out_data4, exp_b); end
        recv[out_ch4]++;
      end
      for (int k = 0; k < 4; k++) if (in_x[k]) sent[k]++;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (recv[k] !== sent[k]) begin bad++; $display("FAIL soak_count ch=%0d got=%0d exp=%0d", k, recv[k], sent[k]); end
    end
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL soak_empty got=%b exp=0", out_valid4); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_fair();
    test_backpressure();
    test_nonpow2();
    test_mode_switch();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
